// File: rtl/fwd_ctrl.sv
// fwd_ctrl: operand-forwarding and load-use hazard controller for TinyV.
// A shadow pipeline tracks the destinations of the EX/MEM/WB instructions.
// From it the block drives the ALU operand mux selects and raises a one-cycle
// stall when a load result is needed by the very next instruction.
module fwd_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_reg_write,
  input  logic                      id_is_load,
  input  logic                      flush,
  output logic [1:0]                fwd_a_sel,
  output logic [1:0]                fwd_b_sel,
  output logic                      stall,
  output logic [CNT_WIDTH-1:0]      stall_count
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = {REG_ADDR_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]      CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]      CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // EX stage shadow
  logic                      ex_valid_r;
  logic [REG_ADDR_WIDTH-1:0] ex_rs1_r;
  logic [REG_ADDR_WIDTH-1:0] ex_rs2_r;
  logic                      ex_use_rs1_r;
  logic                      ex_use_rs2_r;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_r;
  logic                      ex_reg_write_r;
  logic                      ex_is_load_r;
  // MEM stage shadow; the load flag is not kept here because the stall
  // already keeps every load consumer at least two stages behind it.
  logic                      mem_valid_r;
  logic [REG_ADDR_WIDTH-1:0] mem_rd_r;
  logic                      mem_reg_write_r;
  // WB stage shadow
  logic                      wb_valid_r;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_r;
  logic                      wb_reg_write_r;

  logic                      stall_s;
  logic                      ex_load_s;
  logic [1:0]                fwd_a_s;
  logic [1:0]                fwd_b_s;
  logic [CNT_WIDTH-1:0]      stall_count_r;

  // A stage can supply register r when it is live, writes, and r is not x0.
  function automatic logic is_source(
    input logic                      valid,
    input logic                      reg_write,
    input logic [REG_ADDR_WIDTH-1:0] rd,
    input logic [REG_ADDR_WIDTH-1:0] r
  );
    return valid && reg_write && (rd == r) && (rd != REG_ZERO);
  endfunction

  // Pick the mux select for one operand; MEM is younger, so it wins over WB.
  function automatic logic [1:0] pick_sel(
    input logic                      use_r,
    input logic [REG_ADDR_WIDTH-1:0] r,
    input logic                      ex_valid,
    input logic                      mem_valid,
    input logic                      mem_wr,
    input logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input logic                      wb_valid,
    input logic                      wb_wr,
    input logic [REG_ADDR_WIDTH-1:0] wb_rd
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (!(ex_valid && use_r)) begin
      sel = SEL_RF;
    end else if (is_source(mem_valid, mem_wr, mem_rd, r)) begin
      sel = SEL_MEM;
    end else if (is_source(wb_valid, wb_wr, wb_rd, r)) begin
      sel = SEL_WB;
    end else begin
      sel = SEL_RF;
    end
    return sel;
  endfunction

  // Load-use detection against the load currently in EX, and the EX load enable.
  always_comb begin
    stall_s   = 1'b0;
    ex_load_s = 1'b0;
    if (id_valid && ex_valid_r && ex_is_load_r && ex_reg_write_r && (ex_rd_r != REG_ZERO)) begin
      stall_s = (id_use_rs1 && (id_rs1 == ex_rd_r)) || (id_use_rs2 && (id_rs2 == ex_rd_r));
    end else begin
      stall_s = 1'b0;
    end
    ex_load_s = id_valid && !stall_s && !flush;
  end

  // Operand mux selects from registered stage state only.
  always_comb begin
    fwd_a_s = pick_sel(ex_use_rs1_r, ex_rs1_r, ex_valid_r,
                       mem_valid_r, mem_reg_write_r, mem_rd_r,
                       wb_valid_r, wb_reg_write_r, wb_rd_r);
    fwd_b_s = pick_sel(ex_use_rs2_r, ex_rs2_r, ex_valid_r,
                       mem_valid_r, mem_reg_write_r, mem_rd_r,
                       wb_valid_r, wb_reg_write_r, wb_rd_r);
  end

  // Shadow pipeline: EX takes ID or a bubble, MEM and WB always advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_r      <= 1'b0;
      ex_rs1_r        <= REG_ZERO;
      ex_rs2_r        <= REG_ZERO;
      ex_use_rs1_r    <= 1'b0;
      ex_use_rs2_r    <= 1'b0;
      ex_rd_r         <= REG_ZERO;
      ex_reg_write_r  <= 1'b0;
      ex_is_load_r    <= 1'b0;
      mem_valid_r     <= 1'b0;
      mem_rd_r        <= REG_ZERO;
      mem_reg_write_r <= 1'b0;
      wb_valid_r      <= 1'b0;
      wb_rd_r         <= REG_ZERO;
      wb_reg_write_r  <= 1'b0;
    end else begin
      if (ex_load_s) begin
        ex_valid_r     <= 1'b1;
        ex_rs1_r       <= id_rs1;
        ex_rs2_r       <= id_rs2;
        ex_use_rs1_r   <= id_use_rs1;
        ex_use_rs2_r   <= id_use_rs2;
        ex_rd_r        <= id_rd;
        ex_reg_write_r <= id_reg_write;
        ex_is_load_r   <= id_is_load;
      end else begin
        ex_valid_r     <= 1'b0;
      end
      mem_valid_r     <= ex_valid_r;
      mem_rd_r        <= ex_rd_r;
      mem_reg_write_r <= ex_reg_write_r;
      wb_valid_r      <= mem_valid_r;
      wb_rd_r         <= mem_rd_r;
      wb_reg_write_r  <= mem_reg_write_r;
    end
  end

  // Saturating count of stall cycles the pipeline actually honours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_r <= CNT_ZERO;
    end else if (stall_s && !flush && !(&stall_count_r)) begin
      stall_count_r <= stall_count_r + CNT_ONE;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign fwd_a_sel   = fwd_a_s;
  assign fwd_b_sel   = fwd_b_s;
  assign stall       = stall_s;
  assign stall_count = stall_count_r;

endmodule
